// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI4-Lite to dual-port RAM bridge:
// FSM encoding, response codes and the write-strobe patterns.
package axi_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_BRESP,
    ST_RD,
    ST_RCAP,
    ST_RRESP
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI lane strobes accepted by the bridge
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_B1   = 4'b0010;
  localparam logic [3:0] STRB_B2   = 4'b0100;
  localparam logic [3:0] STRB_B3   = 4'b1000;
  localparam logic [3:0] STRB_H0   = 4'b0011;
  localparam logic [3:0] STRB_H1   = 4'b0110;
  localparam logic [3:0] STRB_H2   = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // RAM size masks (data right-aligned, offset carried in the address)
  localparam logic [3:0] SIZE_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_HALF = 4'b0011;
  localparam logic [3:0] SIZE_WORD = 4'b1111;

endpackage

// File: rtl/axi_wstrb_normalize.sv
// Converts an AXI lane-aligned strobe/data pair into the RAM's right-aligned
// size-mask form, flagging empty and unsupported strobe patterns.
module axi_wstrb_normalize
  import axi_ram_pkg::*;
(
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_wdata,
  output logic [1:0]  offset,
  output logic        legal,
  output logic        empty
);

  always_comb begin
    ram_wstrb = 4'b0000;
    offset    = addr_lo;
    legal     = 1'b0;
    empty     = 1'b0;
    case (wstrb)
      STRB_NONE: empty = 1'b1;
      STRB_B0:   begin ram_wstrb = SIZE_BYTE; offset = 2'd0; legal = 1'b1; end
      STRB_B1:   begin ram_wstrb = SIZE_BYTE; offset = 2'd1; legal = 1'b1; end
      STRB_B2:   begin ram_wstrb = SIZE_BYTE; offset = 2'd2; legal = 1'b1; end
      STRB_B3:   begin ram_wstrb = SIZE_BYTE; offset = 2'd3; legal = 1'b1; end
      STRB_H0:   begin ram_wstrb = SIZE_HALF; offset = 2'd0; legal = 1'b1; end
      STRB_H1:   begin ram_wstrb = SIZE_HALF; offset = 2'd1; legal = 1'b1; end
      STRB_H2:   begin ram_wstrb = SIZE_HALF; offset = 2'd2; legal = 1'b1; end
      STRB_W:    begin ram_wstrb = SIZE_WORD; offset = 2'd0; legal = 1'b1; end
      default:   ;
    endcase
    ram_wdata = wdata >> {offset, 3'b000};
  end

endmodule

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave driving port B of ram_dualport with single-beat accesses,
// one access in flight and a dead cycle after every RAM write.
module axi_lite_ram_bridge
  import axi_ram_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [ADDR_W-1:0] S_AWADDR,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  input  logic [31:0]       S_WDATA,
  input  logic [3:0]        S_WSTRB,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  output logic [1:0]        S_BRESP,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  input  logic [ADDR_W-1:0] S_ARADDR,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  output logic [31:0]       S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              RAM_RDEN,
  output logic [WIDTH+1:0]  RAM_RADDR,
  input  logic [31:0]       RAM_RDATA,
  output logic              RAM_WREN,
  output logic [3:0]        RAM_WSTRB,
  output logic [WIDTH+1:0]  RAM_WADDR,
  output logic [31:0]       RAM_WDATA
);

  state_t           state_reg;
  grant_t           last_grant_reg;
  logic             aw_full_reg;
  logic             w_full_reg;
  logic [WIDTH-1:0] aw_word_reg;
  logic [1:0]       aw_lo_reg;
  logic [31:0]      w_data_reg;
  logic [3:0]       w_strb_reg;
  logic [WIDTH-1:0] ar_word_reg;
  logic [1:0]       bresp_reg;
  logic [31:0]      rdata_reg;

  logic        live;
  logic        idle;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        wr_ready;
  logic        wr_sel;
  logic        wr_fire;
  logic        rd_fire;
  logic [3:0]  norm_wstrb;
  logic [31:0] norm_wdata;
  logic [1:0]  norm_offset;
  logic        norm_legal;
  logic        norm_empty;
  logic        unused_addr_bits;

  // The RAM aliases: byte-address bits above the word index are ignored.
  assign unused_addr_bits = ^{S_AWADDR[ADDR_W-1:WIDTH+2], S_ARADDR[ADDR_W-1:WIDTH+2],
                              S_ARADDR[1:0]};

  // Everything is forced low while reset is asserted, so no enable can
  // escape in the cycle reset is first seen.
  assign live = !RST;
  assign idle = (state_reg == ST_IDLE);

  assign S_AWREADY = live && idle && !aw_full_reg;
  assign S_WREADY  = live && idle && !w_full_reg;
  assign aw_hs     = S_AWVALID && S_AWREADY;
  assign w_hs      = S_WVALID && S_WREADY;

  // A write counts as ready in the cycle its last half arrives, which keeps
  // the handshake-to-WREN latency at one cycle.
  assign wr_ready  = (aw_full_reg || aw_hs) && (w_full_reg || w_hs);
  assign wr_sel    = idle && wr_ready && (!S_ARVALID || last_grant_reg == GRANT_READ);
  assign S_ARREADY = live && idle && !wr_sel;
  assign ar_hs     = S_ARVALID && S_ARREADY;

  axi_wstrb_normalize u_norm (
    .wstrb     (w_strb_reg),
    .wdata     (w_data_reg),
    .addr_lo   (aw_lo_reg),
    .ram_wstrb (norm_wstrb),
    .ram_wdata (norm_wdata),
    .offset    (norm_offset),
    .legal     (norm_legal),
    .empty     (norm_empty)
  );

  assign wr_fire   = live && (state_reg == ST_WR) && norm_legal;
  assign rd_fire   = live && (state_reg == ST_RD);

  assign RAM_WREN  = wr_fire;
  assign RAM_WSTRB = wr_fire ? norm_wstrb : 4'b0000;
  assign RAM_WADDR = wr_fire ? {aw_word_reg, norm_offset} : '0;
  assign RAM_WDATA = wr_fire ? norm_wdata : 32'h0;
  assign RAM_RDEN  = rd_fire;
  assign RAM_RADDR = rd_fire ? {ar_word_reg, 2'b00} : '0;

  assign S_BVALID  = live && (state_reg == ST_BRESP);
  assign S_BRESP   = S_BVALID ? bresp_reg : RESP_OKAY;
  assign S_RVALID  = live && (state_reg == ST_RRESP);
  assign S_RDATA   = S_RVALID ? rdata_reg : 32'h0;
  assign S_RRESP   = RESP_OKAY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_READ;
      aw_full_reg    <= 1'b0;
      w_full_reg     <= 1'b0;
      aw_word_reg    <= '0;
      aw_lo_reg      <= 2'b00;
      w_data_reg     <= 32'h0;
      w_strb_reg     <= 4'b0000;
      ar_word_reg    <= '0;
      bresp_reg      <= RESP_OKAY;
      rdata_reg      <= 32'h0;
    end else begin
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_word_reg <= S_AWADDR[WIDTH+1:2];
        aw_lo_reg   <= S_AWADDR[1:0];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= S_WDATA;
        w_strb_reg <= S_WSTRB;
      end
      case (state_reg)
        ST_IDLE: begin
          if (wr_sel) begin
            state_reg      <= ST_WR;
            last_grant_reg <= GRANT_WRITE;
          end else if (ar_hs) begin
            state_reg      <= ST_RD;
            ar_word_reg    <= S_ARADDR[WIDTH+1:2];
            last_grant_reg <= GRANT_READ;
          end
        end
        ST_WR: begin
          aw_full_reg <= 1'b0;
          w_full_reg  <= 1'b0;
          bresp_reg   <= (norm_legal || norm_empty) ? RESP_OKAY : RESP_SLVERR;
          state_reg   <= ST_BRESP;
        end
        ST_BRESP: if (S_BREADY) state_reg <= ST_IDLE;
        ST_RD:    state_reg <= ST_RCAP;
        // RAM_RDATA changes every cycle; this is the only cycle it is ours.
        ST_RCAP: begin
          rdata_reg <= RAM_RDATA;
          state_reg <= ST_RRESP;
        end
        ST_RRESP: if (S_RREADY) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Randomized bench for axi_lite_ram_bridge: a behavioural RAM on port B and a
// byte-lane reference memory that predicts every read and write response.
module tb_axi_lite_ram_bridge;

  localparam int WIDTH  = 10;
  localparam int ADDR_W = 32;

  logic              CLK, RST;
  logic              S_AWVALID, S_AWREADY, S_WVALID, S_WREADY;
  logic [ADDR_W-1:0] S_AWADDR, S_ARADDR;
  logic [31:0]       S_WDATA, S_RDATA;
  logic [3:0]        S_WSTRB;
  logic              S_BVALID, S_BREADY, S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [1:0]        S_BRESP, S_RRESP;
  logic              RAM_RDEN, RAM_WREN;
  logic [WIDTH+1:0]  RAM_RADDR, RAM_WADDR;
  logic [31:0]       RAM_RDATA, RAM_WDATA;
  logic [3:0]        RAM_WSTRB;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] ram_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  int         wr_cyc = -1, rd_cyc = -1, wren_cnt = 0;
  logic       prev_wren = 1'b0;
  logic       viol;
  logic [11:0] wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;

  axi_lite_ram_bridge #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .RAM_RDEN(RAM_RDEN), .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA),
    .RAM_WREN(RAM_WREN), .RAM_WSTRB(RAM_WSTRB), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Port-B RAM: size-mask write at byte offset, registered read that shows
  // garbage whenever RDEN was low.
  always @(posedge CLK) begin : ram_model
    logic [31:0] word;
    int idx;
    if (RAM_WREN) begin
      word = ram_mem[RAM_WADDR[11:2]];
      for (int k = 0; k < 4; k++) begin
        idx = int'(RAM_WADDR[1:0]) + k;
        if (RAM_WSTRB[k] && idx < 4) word[8*idx +: 8] = RAM_WDATA[8*k +: 8];
      end
      ram_mem[RAM_WADDR[11:2]] <= word;
    end
    RAM_RDATA <= RAM_RDEN ? ram_mem[RAM_RADDR[11:2]] : $urandom;
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      viol = (RAM_RDEN && RAM_WREN) || (prev_wren && (RAM_RDEN || RAM_WREN))
          || (!RAM_WREN && (RAM_WADDR != 0 || RAM_WSTRB != 0 || RAM_WDATA != 0))
          || (!RAM_RDEN && RAM_RADDR != 0);
      check_eq("ram_port_rules", 64'(viol), 64'(0));
      if (RAM_WREN) begin
        wr_cyc = cyc; wr_addr = RAM_WADDR; wr_strb = RAM_WSTRB; wr_data = RAM_WDATA;
        wren_cnt++;
      end
      if (RAM_RDEN) rd_cyc = cyc;
      prev_wren = RAM_WREN;
    end
  end

  function automatic logic [1:0] ref_resp(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b0110, 4'b1111: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int b_delay, output logic [1:0] resp);
    logic aw_done, w_done, aw_ok, w_ok, got, exp_wr;
    logic [1:0] exp_resp;
    logic [31:0] word;
    int n, hs_cyc, b_cyc, wren_before;
    exp_resp = ref_resp(strb);
    exp_wr = (strb != 4'b0000) && (exp_resp == 2'b00);
    aw_done = 0; w_done = 0; got = 0; n = 0; hs_cyc = -1; b_cyc = -1; resp = 2'b11;
    wren_before = wren_cnt;
    S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb; S_BREADY = 1'b0;
    S_WVALID = 1'b1; S_AWVALID = (aw_delay == 0);
    while (!(aw_done && w_done) && n < 40) begin
      @(negedge CLK);
      aw_ok = S_AWVALID && S_AWREADY;
      w_ok  = S_WVALID && S_WREADY;
      if (aw_ok || w_ok) hs_cyc = cyc;
      tick(); n++;
      if (aw_ok) begin aw_done = 1; S_AWVALID = 1'b0; end
      if (w_ok)  begin w_done = 1;  S_WVALID = 1'b0; end
      if (!aw_done && n >= aw_delay) S_AWVALID = 1'b1;
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check_eq("aw_w_accept", 64'(aw_done && w_done), 64'(1));
    n = 0;
    while (!got && n < 40) begin
      @(negedge CLK);
      if (S_BVALID) begin got = 1; b_cyc = cyc; resp = S_BRESP; end
      else begin tick(); n++; end
    end
    check_eq("bvalid_seen", 64'(got), 64'(1));
    check_eq("bresp", 64'(resp), 64'(exp_resp));
    check_eq("bvalid_latency", 64'(b_cyc), 64'(hs_cyc + 2));
    check_eq("wren_count", 64'(wren_cnt - wren_before), 64'(exp_wr ? 1 : 0));
    if (exp_wr) check_eq("wren_latency", 64'(wr_cyc), 64'(hs_cyc + 1));
    for (int i = 0; i < b_delay; i++) begin
      tick();
      @(negedge CLK);
      check_eq("bresp_hold", 64'({S_BVALID, S_BRESP}), 64'({1'b1, exp_resp}));
    end
    tick(); S_BREADY = 1'b1;
    @(negedge CLK);
    tick(); S_BREADY = 1'b0;
    @(negedge CLK);
    check_eq("bvalid_drop", 64'(S_BVALID), 64'(0));
    tick();
    if (exp_wr) begin
      word = ref_mem[addr[11:2]];
      for (int i = 0; i < 4; i++) if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
      ref_mem[addr[11:2]] = word;
    end
    $display("WR addr=%h data=%h strb=%b aw_delay=%0d resp=%b", addr, data, strb, aw_delay, resp);
  endtask

  task automatic wait_arready(output logic ok, output int ar_cyc);
    int n;
    ok = 0; n = 0; ar_cyc = -1;
    while (!ok && n < 40) begin
      @(negedge CLK);
      if (S_ARREADY) begin ok = 1; ar_cyc = cyc; end
      tick(); n++;
    end
    S_ARVALID = 1'b0;
    check_eq("ar_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_rvalid(output int rv_cyc, output logic [31:0] data);
    logic got;
    int n;
    got = 0; n = 0; rv_cyc = -1; data = 32'h0;
    while (!got && n < 40) begin
      @(negedge CLK);
      if (S_RVALID) begin got = 1; rv_cyc = cyc; data = S_RDATA; end
      else begin tick(); n++; end
    end
    check_eq("rvalid_seen", 64'(got), 64'(1));
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_delay, input logic rst_pulse,
                         output logic [31:0] data);
    logic ok;
    int ar_cyc, rv_cyc;
    logic [31:0] exp;
    exp = ref_mem[addr[11:2]];
    S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    wait_arready(ok, ar_cyc);
    wait_rvalid(rv_cyc, data);
    check_eq("rdata", 64'(data), 64'(exp));
    check_eq("rvalid_latency", 64'(rv_cyc), 64'(ar_cyc + 3));
    check_eq("rden_latency", 64'(rd_cyc), 64'(ar_cyc + 1));
    for (int i = 0; i < r_delay; i++) begin
      tick();
      @(negedge CLK);
      check_eq("rdata_hold", 64'({S_RVALID, S_RDATA}), 64'({1'b1, exp}));
    end
    if (rst_pulse) begin
      tick(); RST = 1'b1;
      @(negedge CLK);
      check_eq("rst_rvalid", 64'(S_RVALID), 64'(0));
      tick(); RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        check_eq("rst_quiet", 64'({S_RVALID, RAM_RDEN, RAM_WREN}), 64'(0));
        tick();
      end
    end else begin
      tick(); S_RREADY = 1'b1;
      @(negedge CLK);
      tick(); S_RREADY = 1'b0;
      @(negedge CLK);
      check_eq("rvalid_drop", 64'(S_RVALID), 64'(0));
      tick();
    end
    $display("RD addr=%h data=%h hold=%0d rst=%0d", addr, data, r_delay, rst_pulse);
  endtask

  initial begin : main
    logic [1:0]  resp;
    logic [31:0] rd, a;
    logic        ok;
    int          arb_hs, ar_c, rv_c;

    for (int i = 0; i < 1024; i++) begin ram_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    RST = 1'b1;
    S_AWVALID = 1'b1; S_AWADDR = 32'h0; S_WVALID = 1'b0; S_WDATA = 32'h0; S_WSTRB = 4'h0;
    S_BREADY = 1'b0; S_ARVALID = 1'b0; S_ARADDR = 32'h0; S_RREADY = 1'b0;

    repeat (3) begin
      @(negedge CLK);
      check_eq("reset_outputs", 64'(|{S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID,
                                      S_RDATA, S_RRESP, RAM_RDEN, RAM_RADDR, RAM_WREN, RAM_WSTRB,
                                      RAM_WADDR, RAM_WDATA}), 64'(0));
    end
    tick();
    RST = 1'b0; S_AWVALID = 1'b0;
    @(negedge CLK);
    check_eq("ready_after_reset", 64'({S_AWREADY, S_WREADY, S_ARREADY}), 64'(3'b111));
    tick();

    do_write(32'h004, 32'hDEADBEEF, 4'b1111, 0, 0, resp);
    check_eq("word_waddr", 64'(wr_addr), 64'(12'h004));
    check_eq("word_wstrb", 64'(wr_strb), 64'(4'b1111));
    do_read(32'h004, 0, 1'b0, rd);
    check_eq("word_rdata", 64'(rd), 64'(32'hDEADBEEF));

    do_write(32'h008, 32'h11223344, 4'b1111, 0, 0, resp);
    do_write(32'h008, 32'h00AB0000, 4'b0100, 0, 0, resp);
    check_eq("byte_waddr", 64'(wr_addr), 64'(12'h00A));
    check_eq("byte_wstrb", 64'(wr_strb), 64'(4'b0001));
    check_eq("byte_wdata", 64'(wr_data), 64'(32'h000000AB));
    do_read(32'h008, 0, 1'b0, rd);
    check_eq("byte_merge", 64'(rd), 64'(32'h11AB3344));

    do_write(32'h00C, 32'h55555555, 4'b0101, 0, 1, resp);
    check_eq("illegal_slverr", 64'(resp), 64'(2'b10));
    do_write(32'h00C, 32'h66666666, 4'b0000, 0, 0, resp);
    check_eq("empty_okay", 64'(resp), 64'(2'b00));

    // Write and read presented together after a read: write must win.
    do_read(32'h004, 0, 1'b0, rd);
    S_AWADDR = 32'h010; S_WDATA = 32'hCAFEF00D; S_WSTRB = 4'b1111;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARADDR = 32'h004; S_ARVALID = 1'b1;
    S_BREADY = 1'b1; S_RREADY = 1'b0;
    @(negedge CLK);
    check_eq("arb_ready", 64'({S_AWREADY, S_WREADY, S_ARREADY}), 64'(3'b110));
    arb_hs = cyc;
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    wait_arready(ok, ar_c);
    check_eq("arb_write_first", 64'(wr_cyc), 64'(arb_hs + 1));
    check_eq("arb_read_after", 64'(ar_c > wr_cyc), 64'(1));
    ref_mem[4] = 32'hCAFEF00D;
    wait_rvalid(rv_c, rd);
    check_eq("arb_rdata", 64'(rd), 64'(ref_mem[1]));
    tick(); S_RREADY = 1'b1;
    @(negedge CLK);
    tick(); S_RREADY = 1'b0; S_BREADY = 1'b0;
    do_read(32'h010, 0, 1'b0, rd);

    do_write(32'h014, 32'h0BADF00D, 4'b1100, 4, 0, resp);
    do_read(32'h014, 5, 1'b0, rd);

    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), resp);
      else
        do_read(a, int'($urandom_range(0, 2)), 1'b0, rd);
    end

    do_read(32'h008, 5, 1'b1, rd);
    do_read(32'h004, 0, 1'b0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

endmodule
